// File: rtl/breakout_pkg.sv
// Shared screen geometry, colours and drawer state encoding for the breakout display path.
package breakout_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/paddle_drawer_rect_scanner.sv
// Row-major col/row counter pair sweeping a W x H rectangle; last flags the final pixel.
module rect_scanner #(
    parameter int W = 16,
    parameter int H = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [4:0] col,
    output logic [1:0] row,
    output logic       last
);

    localparam logic [4:0] COL_LAST = 5'(W - 1);
    localparam logic [1:0] ROW_LAST = 2'(H - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col <= 5'd0;
            row <= 2'd0;
        end else if (enable) begin
            if (col == COL_LAST) begin
                col <= 5'd0;
                row <= (row == ROW_LAST) ? 2'd0 : row + 2'd1;
            end else begin
                col <= col + 5'd1;
            end
        end
    end

    assign last = (col == COL_LAST) && (row == ROW_LAST);

endmodule

// File: rtl/paddle_drawer.sv
// Redraws the paddle on each frame tick: erases the old rectangle, then plots the new one.
module paddle_drawer
    import breakout_pkg::*;
#(
    parameter int         PADDLE_W  = 16,
    parameter int         PADDLE_H  = 2,
    parameter int         PADDLE_Y  = 112,
    parameter logic [2:0] FG_COLOUR = COLOUR_WHITE,
    parameter logic [2:0] BG_COLOUR = COLOUR_BLACK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] paddle_x,
    input  logic       go,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [6:0] PADDLE_Y7 = 7'(PADDLE_Y);

    draw_state_t state;
    logic [7:0]  old_x;
    logic [7:0]  new_x;
    logic        old_valid;

    logic [4:0]  col;
    logic [1:0]  row;
    logic        last;
    logic        scan_clear;
    logic        scan_enable;
    logic [7:0]  base;
    logic [8:0]  xsum;
    logic        in_range;

    // Counters stay zeroed while idle and are re-zeroed at the erase/draw handover.
    assign scan_clear  = (state == ST_IDLE) || ((state == ST_ERASE) && last);
    assign scan_enable = (state == ST_ERASE) || (state == ST_DRAW);

    rect_scanner #(
        .W(PADDLE_W),
        .H(PADDLE_H)
    ) u_scanner (
        .clk   (clk),
        .reset (reset),
        .clear (scan_clear),
        .enable(scan_enable),
        .col   (col),
        .row   (row),
        .last  (last)
    );

    assign base     = (state == ST_ERASE) ? old_x : new_x;
    assign xsum     = {1'b0, base} + {4'd0, col};
    assign in_range = xsum < 9'(SCREEN_W);
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            x         <= 8'd0;
            y         <= 7'd0;
            colour    <= 3'd0;
            plot      <= 1'b0;
            done      <= 1'b0;
            old_x     <= 8'd0;
            new_x     <= 8'd0;
            old_valid <= 1'b0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        new_x <= paddle_x;
                        if (old_valid && (paddle_x == old_x))
                            state <= ST_DONE;
                        else if (!old_valid)
                            state <= ST_DRAW;
                        else
                            state <= ST_ERASE;
                    end
                end
                ST_ERASE: begin
                    x      <= xsum[7:0];
                    y      <= PADDLE_Y7 + {5'd0, row};
                    colour <= BG_COLOUR;
                    plot   <= in_range;
                    if (last)
                        state <= ST_DRAW;
                end
                ST_DRAW: begin
                    x      <= xsum[7:0];
                    y      <= PADDLE_Y7 + {5'd0, row};
                    colour <= FG_COLOUR;
                    plot   <= in_range;
                    if (last)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    old_x     <= new_x;
                    old_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_drawer.sv
// Directed bench for paddle_drawer with hand-derived pixel sequences per scenario.
module tb_paddle_drawer;

    logic       clk;
    logic       reset;
    logic [7:0] paddle_x;
    logic       go;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    logic       cap_plot   [0:80];
    logic       cap_done   [0:80];
    logic       cap_busy   [0:80];
    logic [7:0] cap_x      [0:80];
    logic [6:0] cap_y      [0:80];
    logic [2:0] cap_colour [0:80];

    paddle_drawer dut (
        .clk     (clk),
        .reset   (reset),
        .paddle_x(paddle_x),
        .go      (go),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Go is sampled by the next rising edge (edge 0); returns just after it.
    task automatic start_go(input logic [7:0] px);
        paddle_x = px;
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    // Record outputs on the falling edge of cycles 1..n.
    task automatic capture(input int n);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            cap_plot[k]   = plot;
            cap_done[k]   = done;
            cap_busy[k]   = busy;
            cap_x[k]      = x;
            cap_y[k]      = y;
            cap_colour[k] = colour;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        go = 1'b0;
        paddle_x = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({x, y, colour, plot, done, busy} !== 21'd0) begin
            errors++;
            $display("[TB] FAIL reset_state got x=%0d y=%0d colour=%0d plot=%b done=%b busy=%b want all zero",
                     x, y, colour, plot, done, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_draw(input logic [7:0] px, input string tag);
        logic       e_plot, e_done;
        logic [7:0] e_x;
        logic [6:0] e_y;
        start_go(px);
        capture(34);
        for (int k = 1; k <= 34; k++) begin
            e_plot = (k <= 32);
            e_done = (k == 33);
            e_x = 8'(int'(px) + (k - 1) % 16);
            e_y = 7'(112 + (k - 1) / 16);
            checks++;
            if ({cap_plot[k], cap_done[k]} !== {e_plot, e_done}) begin
                errors++;
                $display("[TB] FAIL %s_strobe cycle %0d got plot=%b done=%b want plot=%b done=%b",
                         tag, k, cap_plot[k], cap_done[k], e_plot, e_done);
            end
            if (e_plot) begin
                checks++;
                if ({cap_x[k], cap_y[k], cap_colour[k]} !== {e_x, e_y, 3'd7}) begin
                    errors++;
                    $display("[TB] FAIL %s_pixel cycle %0d got x=%0d y=%0d c=%0d want x=%0d y=%0d c=7",
                             tag, k, cap_x[k], cap_y[k], cap_colour[k], e_x, e_y);
                end
            end
        end
    endtask

    task automatic test_move();
        logic       e_plot, e_done;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_c;
        int         j;
        int         nplots;
        start_go(8'd71);
        capture(66);
        nplots = 0;
        for (int k = 1; k <= 66; k++) begin
            j = (k <= 32) ? k - 1 : k - 33;
            e_plot = (k <= 64);
            e_done = (k == 65);
            e_x = (k <= 32) ? 8'(70 + j % 16) : 8'(71 + j % 16);
            e_y = 7'(112 + j / 16);
            e_c = (k <= 32) ? 3'd0 : 3'd7;
            if (cap_plot[k] === 1'b1) nplots++;
            checks++;
            if ({cap_plot[k], cap_done[k]} !== {e_plot, e_done}) begin
                errors++;
                $display("[TB] FAIL move_strobe cycle %0d got plot=%b done=%b want plot=%b done=%b",
                         k, cap_plot[k], cap_done[k], e_plot, e_done);
            end
            if (e_plot) begin
                checks++;
                if ({cap_x[k], cap_y[k], cap_colour[k]} !== {e_x, e_y, e_c}) begin
                    errors++;
                    $display("[TB] FAIL move_pixel cycle %0d got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                             k, cap_x[k], cap_y[k], cap_colour[k], e_x, e_y, e_c);
                end
            end
        end
        checks++;
        if (nplots != 64) begin
            errors++;
            $display("[TB] FAIL move_plot_count got %0d want 64", nplots);
        end
    endtask

    task automatic test_unchanged();
        logic busy_at_accept;
        start_go(8'd71);
        busy_at_accept = busy;
        capture(3);
        checks++;
        if (busy_at_accept !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unchanged_busy cycle 0 got %b want 1", busy_at_accept);
        end
        checks++;
        if ({cap_done[1], cap_plot[1], cap_busy[1]} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL unchanged_done cycle 1 got done=%b plot=%b busy=%b want 1 0 0",
                     cap_done[1], cap_plot[1], cap_busy[1]);
        end
        for (int k = 2; k <= 3; k++) begin
            checks++;
            if ({cap_done[k], cap_plot[k]} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL unchanged_quiet cycle %0d got done=%b plot=%b want 0 0",
                         k, cap_done[k], cap_plot[k]);
            end
        end
    endtask

    task automatic test_clip();
        logic       e_plot, e_done;
        int         nplots;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start_go(8'd150);
        capture(34);
        nplots = 0;
        for (int k = 1; k <= 34; k++) begin
            e_plot = (k <= 32) && (((k - 1) % 16) < 10);
            e_done = (k == 33);
            if (cap_plot[k] === 1'b1) nplots++;
            checks++;
            if ({cap_plot[k], cap_done[k]} !== {e_plot, e_done}) begin
                errors++;
                $display("[TB] FAIL clip_strobe cycle %0d got plot=%b done=%b want plot=%b done=%b",
                         k, cap_plot[k], cap_done[k], e_plot, e_done);
            end
            if (e_plot) begin
                checks++;
                if (cap_x[k] !== 8'(150 + (k - 1) % 16)) begin
                    errors++;
                    $display("[TB] FAIL clip_x cycle %0d got %0d want %0d", k, cap_x[k], 150 + (k - 1) % 16);
                end
            end
        end
        checks++;
        if (nplots != 20) begin
            errors++;
            $display("[TB] FAIL clip_plot_count got %0d want 20", nplots);
        end
    endtask

    task automatic test_reset_mid_erase();
        start_go(8'd100);
        capture(9);
        checks++;
        if ({cap_plot[9], cap_x[9], cap_colour[9]} !== {1'b1, 8'd158, 3'd0}) begin
            errors++;
            $display("[TB] FAIL erase_before_reset got plot=%b x=%0d c=%0d want plot=1 x=158 c=0",
                     cap_plot[9], cap_x[9], cap_colour[9]);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_abandon got plot=%b busy=%b done=%b want 0 0 0", plot, busy, done);
        end
        reset = 1'b0;
        test_first_draw(8'd40, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic       e_plot, e_done;
        logic [7:0] e_x;
        logic [2:0] e_c;
        int         j;
        int         nplots, ndones, waited;
        start_go(8'd60);
        nplots = 0;
        ndones = 0;
        for (int k = 1; k <= 66; k++) begin
            @(posedge clk);
            @(negedge clk);
            j = (k <= 32) ? k - 1 : k - 33;
            e_plot = (k <= 64);
            e_done = (k == 65);
            e_x = (k <= 32) ? 8'(40 + j % 16) : 8'(60 + j % 16);
            e_c = (k <= 32) ? 3'd0 : 3'd7;
            if (plot === 1'b1) nplots++;
            if (done === 1'b1) ndones++;
            checks++;
            if ({plot, done} !== {e_plot, e_done}) begin
                errors++;
                $display("[TB] FAIL b2b_strobe cycle %0d got plot=%b done=%b want plot=%b done=%b",
                         k, plot, done, e_plot, e_done);
            end
            if (e_plot) begin
                checks++;
                if ({x, colour} !== {e_x, e_c}) begin
                    errors++;
                    $display("[TB] FAIL b2b_pixel cycle %0d got x=%0d c=%0d want x=%0d c=%0d",
                             k, x, colour, e_x, e_c);
                end
            end
            go = (k == 4) || (k == 31);
            paddle_x = go ? 8'd90 : 8'd60;
        end
        go = 1'b0;
        checks++;
        if ({nplots, ndones} !== {32'd64, 32'd1}) begin
            errors++;
            $display("[TB] FAIL b2b_counts got plots=%0d dones=%0d want 64 1", nplots, ndones);
        end
        // Old position is now 60, so a go to 90 must start by erasing at x=60.
        start_go(8'd90);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({plot, x, y, colour} !== {1'b1, 8'd60, 7'd112, 3'd0}) begin
            errors++;
            $display("[TB] FAIL next_go_erase got plot=%b x=%0d y=%0d c=%0d want 1 60 112 0",
                     plot, x, y, colour);
        end
        waited = 1;
        while (done !== 1'b1 && waited < 200) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited != 65) begin
            errors++;
            $display("[TB] FAIL next_go_done got done at cycle %0d want 65", waited);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        go = 1'b0;
        paddle_x = 8'd0;
        test_reset();
        test_first_draw(8'd70, "first_draw");
        test_move();
        test_unchanged();
        test_clip();
        test_reset_mid_erase();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
